// File: rtl/repeated_pattern_detector.sv
// Receive side of the repeated-pattern mask stream.
// Captures CAP_LEN serial bits, searches for the smallest repeating period
// (1..MAX_W), then checks every further bit against the bit one period back.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   clk_en     global enable; when low every register holds
//   start      1-cycle pulse: clear and (re)arm detection (highest priority)
//   bit_in     serial mask bit
//   bit_valid  bit_in qualifier
//   pattern_w  detected period, 0 when no period has been found
//   pattern    [0:31], pattern[i] = i-th captured bit for i < pattern_w
//   locked     high while in LOCKED
//   no_lock    high while in FAIL
//   mismatch   1-cycle pulse on the first post-lock bit error
//   busy       high in CAPTURE or SEARCH
module repeated_pattern_detector #(
  parameter int unsigned MAX_W   = 31,
  parameter int unsigned CAP_LEN = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        start,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic [4:0]  pattern_w,
  output logic [0:31] pattern,
  output logic        locked,
  output logic        no_lock,
  output logic        mismatch,
  output logic        busy
);

  localparam int unsigned CNT_W  = 7;
  localparam int unsigned CAND_W = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_SEARCH,
    S_LOCKED,
    S_FAIL
  } state_t;

  state_t              state, state_n;
  logic [CAP_LEN-1:0]  cap, cap_n;
  logic [MAX_W-1:0]    hist, hist_n;
  logic [CNT_W-1:0]    cap_cnt, cap_cnt_n;
  logic [CAND_W-1:0]   cand, cand_n;
  logic [4:0]          pattern_w_n;
  logic [0:31]         pattern_n;
  logic                locked_n, no_lock_n, mismatch_n, busy_n;
  logic [31:0]         match_vec;
  logic [MAX_W-1:0]    hist_sh;

  // True when the frozen capture repeats with period w over its whole length.
  function automatic logic period_match(input logic [CAP_LEN-1:0] c, input int w);
    logic m;
    m = 1'b1;
    for (int i = 0; i < int'(CAP_LEN) - w; i++) begin
      m = m & ~(c[i] ^ c[i+w]);
    end
    return m;
  endfunction

  // Match result for every candidate period; bit 0 is unused.
  always_comb begin
    match_vec = '0;
    for (int w = 1; w <= int'(MAX_W); w++) begin
      match_vec[w] = period_match(cap, w);
    end
  end

  // hist[0] is always the newest bit.
  assign hist_sh = {hist[MAX_W-2:0], bit_in};

  // Next-state and datapath update.
  always_comb begin
    state_n     = state;
    cap_n       = cap;
    hist_n      = hist;
    cap_cnt_n   = cap_cnt;
    cand_n      = cand;
    pattern_w_n = pattern_w;
    pattern_n   = pattern;
    mismatch_n  = 1'b0;

    if (start) begin
      // A beat coinciding with start is dropped.
      state_n     = S_CAPTURE;
      cap_cnt_n   = '0;
      cand_n      = '0;
      hist_n      = '0;
      pattern_w_n = '0;
      pattern_n   = '0;
    end else begin
      unique case (state)
        S_IDLE: ;
        S_CAPTURE: begin
          if (bit_valid) begin
            for (int i = 0; i < int'(CAP_LEN); i++) begin
              if (cap_cnt == CNT_W'(i)) cap_n[i] = bit_in;
            end
            hist_n    = hist_sh;
            cap_cnt_n = CNT_W'(cap_cnt + CNT_W'(1));
            if (cap_cnt == CNT_W'(CAP_LEN - 1)) begin
              state_n = S_SEARCH;
              cand_n  = CAND_W'(1);
            end
          end
        end
        S_SEARCH: begin
          // Bits arriving here keep the history aligned but are not checked.
          if (bit_valid) hist_n = hist_sh;
          if (match_vec[cand]) begin
            state_n     = S_LOCKED;
            pattern_w_n = cand;
            for (int i = 0; i < 32; i++) begin
              pattern_n[i] = (CAND_W'(i) < cand) ? cap[i] : 1'b0;
            end
          end else if (cand == CAND_W'(MAX_W)) begin
            state_n     = S_FAIL;
            pattern_w_n = '0;
            pattern_n   = '0;
          end else begin
            cand_n = CAND_W'(cand + CAND_W'(1));
          end
        end
        S_LOCKED: begin
          if (bit_valid) begin
            hist_n = hist_sh;
            if (bit_in != hist[5'(pattern_w - 5'd1)]) begin
              mismatch_n = 1'b1;
              state_n    = S_FAIL;
            end
          end
        end
        S_FAIL: ;
        default: state_n = S_IDLE;
      endcase
    end

    locked_n  = (state_n == S_LOCKED);
    no_lock_n = (state_n == S_FAIL);
    busy_n    = (state_n == S_CAPTURE) || (state_n == S_SEARCH);
  end

  // State and datapath registers; clk_en freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cap       <= '0;
      hist      <= '0;
      cap_cnt   <= '0;
      cand      <= '0;
      pattern_w <= '0;
      pattern   <= '0;
      locked    <= 1'b0;
      no_lock   <= 1'b0;
      mismatch  <= 1'b0;
      busy      <= 1'b0;
    end else if (clk_en) begin
      state     <= state_n;
      cap       <= cap_n;
      hist      <= hist_n;
      cap_cnt   <= cap_cnt_n;
      cand      <= cand_n;
      pattern_w <= pattern_w_n;
      pattern   <= pattern_n;
      locked    <= locked_n;
      no_lock   <= no_lock_n;
      mismatch  <= mismatch_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_repeated_pattern_detector.sv
// Scoreboard bench for repeated_pattern_detector: the stimulus pushes the
// expected lock/fail/mismatch events, a negedge monitor pops and compares.
module tb_repeated_pattern_detector;

  localparam int K_NONE = 0;
  localparam int K_LOCK = 1;
  localparam int K_FAIL = 2;
  localparam int K_MISM = 3;

  logic        clk, rst, clk_en, start, bit_in, bit_valid;
  logic [4:0]  pattern_w;
  logic [0:31] pattern;
  logic        locked, no_lock, mismatch, busy;

  typedef struct {
    int          kind;
    int          at;
    int          pw;
    logic [31:0] pat;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   en_cnt   = 0;
  logic prev_locked = 1'b0;
  logic prev_no_lock = 1'b0;

  repeated_pattern_detector dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .start(start),
    .bit_in(bit_in), .bit_valid(bit_valid),
    .pattern_w(pattern_w), .pattern(pattern),
    .locked(locked), .no_lock(no_lock), .mismatch(mismatch), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count enabled edges; the DUT's latencies are measured in these.
  always @(posedge clk) if (clk_en) en_cnt <= en_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic take(input int kind);
    exp_t e;
    if (q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", kind, en_cnt);
    end else begin
      e = q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", en_cnt, e.at);
      if (kind != K_MISM) begin
        chk("pattern_w", 32'(pattern_w), e.pw);
        chk("pattern", pattern, e.pat);
        chk("busy_at_event", 32'(busy), 0);
      end
      if (kind == K_LOCK) chk("no_lock_at_lock", 32'(no_lock), 0);
      if (kind == K_FAIL) chk("locked_at_fail", 32'(locked), 0);
    end
  endtask

  // Monitor: react to every output event the DUT presents.
  always @(negedge clk) begin
    if (!rst) begin
      if (mismatch) take(K_MISM);
      if (locked && !prev_locked) take(K_LOCK);
      if (no_lock && !prev_no_lock) take(K_FAIL);
    end
    prev_locked  <= locked;
    prev_no_lock <= no_lock;
  end

  task automatic drive(input logic b, input logic v, input logic e, input logic s);
    bit_in = b; bit_valid = v; clk_en = e; start = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("pending_events", q.size(), 0);
  endtask

  function automatic logic [127:0] rep(input logic [31:0] src, input int w);
    logic [127:0] r;
    for (int k = 0; k < 128; k++) r[k] = src[31 - (k % w)];
    return r;
  endfunction

  // Degree-6 maximal LFSR: no period <= 31 fits in a 64-bit window.
  function automatic logic [127:0] lfsr_seq();
    logic [127:0] r;
    logic [5:0]   l;
    l = 6'd1;
    for (int k = 0; k < 128; k++) begin
      r[k] = l[5];
      l = {l[4:0], l[5] ^ l[4]};
    end
    return r;
  endfunction

  // Send nbeats bits of seq; register the expected event when beat 64 lands.
  task automatic stream(input logic [127:0] seq, input int nbeats, input int flip_k,
                        input int gaps, input int exp_kind, input int exp_w,
                        input logic [31:0] exp_pat);
    int   k;
    int   c;
    logic v, e, b;
    k = 0;
    c = 0;
    while (k < nbeats) begin
      v = (gaps != 0) ? ((c % 3) != 2) : 1'b1;
      e = (gaps != 0) ? ((c % 5) != 4) : 1'b1;
      b = seq[k] ^ (k == flip_k);
      if (v && e) begin
        if (k == 63) begin
          if (exp_kind == K_LOCK) q.push_back('{K_LOCK, en_cnt + 1 + exp_w, exp_w, exp_pat});
          if (exp_kind == K_FAIL) q.push_back('{K_FAIL, en_cnt + 1 + 31, 0, 32'h0});
        end
        if (k == flip_k) begin
          q.push_back('{K_MISM, en_cnt + 1, exp_w, exp_pat});
          q.push_back('{K_FAIL, en_cnt + 1, exp_w, exp_pat});
        end
        k++;
      end
      drive(b, v, e, 1'b0);
      c++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pattern_w"}, 32'(pattern_w), 0);
    chk({tag, "_pattern"}, pattern, 0);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_no_lock"}, 32'(no_lock), 0);
    chk({tag, "_mismatch"}, 32'(mismatch), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Assert rst between edges and confirm outputs clear before the next edge.
  task automatic async_rst(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clk_en = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    #2;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    // Beats in IDLE are ignored.
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b1, 1'b0);
    chk("idle_busy", 32'(busy), 0);

    // Period-24 stream, lock, then the 10th post-lock bit flipped.
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    chk("capture_busy", 32'(busy), 1);
    chk("capture_pattern_w", 32'(pattern_w), 0);
    stream(rep(32'hF30F0F00, 24), 100, 97, 0, K_LOCK, 24, 32'hF30F0F00);
    idle(3);
    wait_drain(50);
    chk("post_mismatch_no_lock", 32'(no_lock), 1);
    chk("post_mismatch_pattern_w", 32'(pattern_w), 24);
    chk("post_mismatch_locked", 32'(locked), 0);

    // Period 2, from a 2-bit and a 4-bit source.
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    stream(rep(32'h80000000, 2), 64, -1, 0, K_LOCK, 2, 32'h80000000);
    wait_drain(20);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    stream(rep(32'hA0000000, 4), 64, -1, 0, K_LOCK, 2, 32'h80000000);
    wait_drain(20);

    // Aperiodic stream: search exhausts all candidates.
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    stream(lfsr_seq(), 64, -1, 0, K_FAIL, 0, 32'h0);
    wait_drain(60);
    chk("search_fail_pattern_w", 32'(pattern_w), 0);
    chk("search_fail_locked", 32'(locked), 0);
    chk("search_fail_no_lock", 32'(no_lock), 1);

    // Restart mid-capture (start carries a beat that must be dropped).
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    stream(rep(32'hF30F0F00, 24), 40, -1, 0, K_NONE, 0, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    stream(rep(32'hF0000000, 8), 64, -1, 0, K_LOCK, 8, 32'hF0000000);
    wait_drain(30);
    // Same stream with bit_valid and clk_en gaps.
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    stream(rep(32'hF0000000, 8), 64, -1, 1, K_LOCK, 8, 32'hF0000000);
    wait_drain(30);

    // Reset mid-SEARCH, then beats without start are ignored.
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    stream(rep(32'hF30F0F00, 24), 64, -1, 0, K_NONE, 0, 32'h0);
    idle(5);
    chk("search_busy", 32'(busy), 1);
    async_rst("rst_search");
    for (int i = 0; i < 70; i++) drive(1'(i % 2), 1'b1, 1'b1, 1'b0);
    check_all_zero("after_rst");

    // Reset mid-LOCKED.
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    stream(rep(32'h80000000, 2), 64, -1, 0, K_LOCK, 2, 32'h80000000);
    wait_drain(20);
    chk("locked_before_rst", 32'(locked), 1);
    async_rst("rst_locked");
    idle(4);
    check_all_zero("after_rst_locked");

    chk("final_queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
